// File: rtl/tx_huge_page_rd_req_if.sv
// TRN transmit bus plus the TX ownership handshake.
// master = MRd issuer, slave = core/arbiter side.
interface tx_huge_page_rd_req_if;
  logic        tx_req;
  logic        tx_gnt;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;

  modport master (
    output tx_req, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    input  tx_gnt, trn_tdst_rdy_n
  );

  modport slave (
    input  tx_req, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    output tx_gnt, trn_tdst_rdy_n
  );
endinterface

// File: rtl/tx_huge_page_rd_req.sv
// Splits each unlocked huge page into 64-bit MRd TLPs, tracks outstanding reads, frees pages in 1/2 alternation.
// Optional: define RD_OUTSTANDING_LIMIT_EN to stall issue at MAX_OUTSTANDING outstanding reads.
module tx_huge_page_rd_req #(
  parameter int MAX_RD_QW       = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         trn_clk,
  input  logic                         reset_n,
  input  logic [15:0]                  cfg_completer_id,
  input  logic [63:0]                  huge_page_addr_1,
  input  logic [63:0]                  huge_page_addr_2,
  input  logic [31:0]                  huge_page_qwords_1,
  input  logic [31:0]                  huge_page_qwords_2,
  input  logic                         huge_page_status_1,
  input  logic                         huge_page_status_2,
  output logic                         huge_page_free_1,
  output logic                         huge_page_free_2,
  input  logic                         rd_cpl_done,
  tx_huge_page_rd_req_if.master        trn
);

  typedef enum logic [2:0] {SEL, ARB, HDR0, HDR1, DRAIN, FREE} state_t;

  state_t      state_q, state_d;
  logic        page2_q, page2_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  tag_q, tag_d;
  logic [5:0]  outstanding_q, outstanding_d;

  logic        sel_status;
  logic [63:0] sel_addr;
  logic [31:0] sel_qwords;
  logic [31:0] len_qw;
  logic [9:0]  len_dw;
  logic        eof_acc;
  logic        cpl_dec;
  logic        credit_ok;

`ifdef RD_OUTSTANDING_LIMIT_EN
  localparam logic [5:0] CREDIT_MAX = 6'(MAX_OUTSTANDING);
`else
  // No credit check; the all-ones ceiling only keeps the 6-bit count from wrapping.
  localparam logic [5:0] CREDIT_MAX = 6'h3F | 6'(MAX_OUTSTANDING);
`endif

  assign sel_status = page2_q ? huge_page_status_2 : huge_page_status_1;
  assign sel_addr   = page2_q ? huge_page_addr_2   : huge_page_addr_1;
  assign sel_qwords = page2_q ? huge_page_qwords_2 : huge_page_qwords_1;
  assign len_qw     = (rem_q > 32'(MAX_RD_QW)) ? 32'(MAX_RD_QW) : rem_q;
  // A 512-qword read is 1024 DW, which the 10-bit length field encodes as 0.
  assign len_dw     = {len_qw[8:0], 1'b0};
  assign eof_acc    = (state_q == HDR1) && !trn.trn_tdst_rdy_n;
  assign cpl_dec    = rd_cpl_done && (outstanding_q != 6'd0);
  assign credit_ok  = outstanding_q < CREDIT_MAX;

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEL;
      page2_q       <= 1'b0;
      addr_q        <= '0;
      rem_q         <= '0;
      tag_q         <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      page2_q       <= page2_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    page2_d       = page2_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    tag_d         = tag_q;
    outstanding_d = outstanding_q + {5'd0, eof_acc} - {5'd0, cpl_dec};
    case (state_q)
      SEL: begin
        if (sel_status) begin
          addr_d  = sel_addr;
          rem_d   = sel_qwords;
          state_d = (sel_qwords == 32'd0) ? DRAIN : ARB;
        end
      end
      ARB: begin
        if (trn.tx_gnt && credit_ok) state_d = HDR0;
      end
      HDR0: begin
        if (!trn.trn_tdst_rdy_n) state_d = HDR1;
      end
      HDR1: begin
        if (!trn.trn_tdst_rdy_n) begin
          addr_d  = addr_q + {29'd0, len_qw, 3'b000};
          rem_d   = rem_q - len_qw;
          tag_d   = tag_q + 5'd1;
          state_d = (rem_q == len_qw) ? DRAIN : ARB;
        end
      end
      DRAIN: begin
        if (outstanding_q == 6'd0) state_d = FREE;
      end
      FREE: begin
        page2_d = !page2_q;
        state_d = SEL;
      end
      default: state_d = SEL;
    endcase
  end

  always_comb begin
    trn.tx_req         = 1'b0;
    trn.trn_td         = '0;
    trn.trn_trem_n     = 8'h00;
    trn.trn_tsof_n     = 1'b1;
    trn.trn_teof_n     = 1'b1;
    trn.trn_tsrc_rdy_n = 1'b1;
    huge_page_free_1   = 1'b0;
    huge_page_free_2   = 1'b0;
    case (state_q)
      ARB: trn.tx_req = 1'b1;
      HDR0: begin
        trn.tx_req         = 1'b1;
        trn.trn_tsof_n     = 1'b0;
        trn.trn_tsrc_rdy_n = 1'b0;
        trn.trn_td         = {1'b0, 7'b01_00000, 14'd0, len_dw,
                              cfg_completer_id, 3'b000, tag_q, 4'hF, 4'hF};
      end
      HDR1: begin
        trn.tx_req         = 1'b1;
        trn.trn_teof_n     = 1'b0;
        trn.trn_tsrc_rdy_n = 1'b0;
        trn.trn_td         = addr_q & {{62{1'b1}}, 2'b00};
      end
      FREE: begin
        huge_page_free_1 = !page2_q;
        huge_page_free_2 = page2_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_huge_page_rd_req.sv
// Randomized self-checking bench for tx_huge_page_rd_req against a page/TLP list model.
// Instance uses MAX_RD_QW=64, MAX_OUTSTANDING=2; the credit scenario adapts to RD_OUTSTANDING_LIMIT_EN.
module tb_tx_huge_page_rd_req;

  localparam int RD_QW = 64;

  typedef struct packed {
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [63:0] addr;
  } tlp_t;

  typedef struct packed {
    int page;
    int cyc;
  } free_t;

  logic        trn_clk = 1'b0;
  logic        reset_n;
  logic [15:0] cfg_completer_id;
  logic [63:0] huge_page_addr_1, huge_page_addr_2;
  logic [31:0] huge_page_qwords_1, huge_page_qwords_2;
  logic        huge_page_status_1, huge_page_status_2;
  logic        huge_page_free_1, huge_page_free_2;
  logic        rd_cpl_done;

  tx_huge_page_rd_req_if bus ();

  tx_huge_page_rd_req #(.MAX_RD_QW(RD_QW), .MAX_OUTSTANDING(2)) dut (
    .trn_clk            (trn_clk),
    .reset_n            (reset_n),
    .cfg_completer_id   (cfg_completer_id),
    .huge_page_addr_1   (huge_page_addr_1),
    .huge_page_addr_2   (huge_page_addr_2),
    .huge_page_qwords_1 (huge_page_qwords_1),
    .huge_page_qwords_2 (huge_page_qwords_2),
    .huge_page_status_1 (huge_page_status_1),
    .huge_page_status_2 (huge_page_status_2),
    .huge_page_free_1   (huge_page_free_1),
    .huge_page_free_2   (huge_page_free_2),
    .rd_cpl_done        (rd_cpl_done),
    .trn                (bus)
  );

  always #5 trn_clk = ~trn_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Knobs written by the test tasks only
  int dst_mode;
  bit gnt_rand;
  bit cpl_auto;
  bit cpl_coinc;
  int cpl_req_n;
  int model_tag;
  int model_cur;
  int start_cyc;
  int got_seen;
  int free_seen;
  tlp_t exp_q[$];

  // Observed state written by the monitor only
  int   cyc = 0;
  int   model_out = 0;
  int   last_dec = 0;
  int   sof_cnt = 0;
  int   stab_err = 0;
  tlp_t got_q[$];
  free_t free_q[$];

  // Monitor: sample on the falling edge, record accepted TLPs, frees and outstanding reads
  logic        pend = 1'b0;
  logic [63:0] p_td;
  logic [2:0]  p_frm;
  logic [31:0] cur_dw0, cur_dw1;
  always @(negedge trn_clk) begin
    logic acc, eof_acc, dec;
    tlp_t t;
    free_t f;
    cyc++;
    if (!reset_n) begin
      model_out = 0;
      pend = 1'b0;
    end else begin
      if (pend && (bus.trn_td !== p_td ||
          {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n} !== p_frm))
        stab_err++;
      pend  = !bus.trn_tsrc_rdy_n && bus.trn_tdst_rdy_n;
      p_td  = bus.trn_td;
      p_frm = {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n};
      acc = !bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n;
      eof_acc = acc && !bus.trn_teof_n;
      if (acc && !bus.trn_tsof_n) begin
        cur_dw0 = bus.trn_td[63:32];
        cur_dw1 = bus.trn_td[31:0];
        sof_cnt++;
      end
      if (eof_acc) begin
        t.dw0 = cur_dw0;
        t.dw1 = cur_dw1;
        t.addr = bus.trn_td;
        got_q.push_back(t);
      end
      dec = rd_cpl_done && (model_out > 0);
      if (dec) last_dec = cyc;
      model_out = model_out + (eof_acc ? 1 : 0) - (dec ? 1 : 0);
      if (huge_page_free_1) begin f.page = 1; f.cyc = cyc; free_q.push_back(f); end
      if (huge_page_free_2) begin f.page = 2; f.cyc = cyc; free_q.push_back(f); end
    end
  end

  // Core-side driver: destination ready pattern and TX grant
  always @(posedge trn_clk) begin
    #1;
    case (dst_mode)
      0: bus.trn_tdst_rdy_n = 1'b0;
      1: bus.trn_tdst_rdy_n = ~bus.trn_tdst_rdy_n;
      2: bus.trn_tdst_rdy_n = 1'($urandom_range(0, 1));
      3: bus.trn_tdst_rdy_n = 1'b1;
      default: bus.trn_tdst_rdy_n = (bus.trn_teof_n == 1'b0);
    endcase
    bus.tx_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Completion responder: only completes reads that are actually outstanding
  int cpl_done_n = 0;
  always @(posedge trn_clk) begin
    logic cpl;
    #2;
    cpl = 1'b0;
    if (reset_n && model_out > 0) begin
      if (cpl_coinc && !bus.trn_teof_n && !bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n)
        cpl = 1'b1;
      else if (cpl_done_n < cpl_req_n) begin
        cpl = 1'b1;
        cpl_done_n++;
      end else if (cpl_auto && $urandom_range(0, 2) == 0)
        cpl = 1'b1;
    end
    rd_cpl_done = cpl;
  end

  task automatic drive_cycle();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic sample_cycle();
    @(negedge trn_clk);
    #1;
  endtask

  // Reference model: split a page into MRds of at most RD_QW qwords
  task automatic gen_expected(input logic [63:0] a, input int unsigned q);
    int unsigned left;
    int unsigned n;
    logic [63:0] off;
    tlp_t t;
    left = q;
    off = '0;
    while (left > 0) begin
      n = (left > RD_QW) ? RD_QW : left;
      t.dw0 = 32'h2000_0000 | ((n * 2) % 1024);
      t.dw1 = {cfg_completer_id, 3'b000, model_tag[4:0], 8'hFF};
      t.addr = a + off;
      exp_q.push_back(t);
      off = off + 64'(n * 8);
      left = left - n;
      model_tag = (model_tag + 1) % 32;
    end
  endtask

  task automatic start_page(input int pg, input logic [63:0] a, input int unsigned q);
    drive_cycle();
    if (pg == 1) begin
      huge_page_addr_1 = a; huge_page_qwords_1 = q; huge_page_status_1 = 1'b1;
    end else begin
      huge_page_addr_2 = a; huge_page_qwords_2 = q; huge_page_status_2 = 1'b1;
    end
    start_cyc = cyc + 1;
    gen_expected(a, q);
  endtask

  task automatic wait_free(input int pg, input bit zero);
    bit found;
    free_t ev;
    int exp_cyc;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      sample_cycle();
      if (free_q.size() > free_seen) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL free_%0d_timeout: got no pulse in 3000 cycles, required one", pg);
      drive_cycle();
    end else begin
      ev = free_q[free_seen];
      free_seen++;
      exp_cyc = zero ? start_cyc + 2 : last_dec + 2;
      n_cmp++;
      if (ev.page !== pg) begin
        n_fail++;
        $display("[TB] FAIL free_page: got page %0d, required page %0d", ev.page, pg);
      end
      n_cmp++;
      if (ev.cyc !== exp_cyc) begin
        n_fail++;
        $display("[TB] FAIL free_%0d_timing: got cycle %0d, required %0d", pg, ev.cyc, exp_cyc);
      end
      drive_cycle();
      if (pg == 1) huge_page_status_1 = 1'b0; else huge_page_status_2 = 1'b0;
      sample_cycle();
      n_cmp++;
      if ((pg == 1 ? huge_page_free_1 : huge_page_free_2) !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL free_%0d_width: pulse still high on 2nd cycle, required 0", pg);
      end
    end
  endtask

  task automatic check_tlps(input string name);
    int n_got;
    n_got = got_q.size() - got_seen;
    n_cmp++;
    if (n_got != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL %s_count: got %0d MRds, required %0d", name, n_got, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      n_cmp++;
      if (got_q[got_seen + i].dw0 !== exp_q[i].dw0) begin
        n_fail++;
        $display("[TB] FAIL %s_dw0[%0d]: got %h, required %h", name, i,
                 got_q[got_seen + i].dw0, exp_q[i].dw0);
      end
      n_cmp++;
      if (got_q[got_seen + i].dw1 !== exp_q[i].dw1) begin
        n_fail++;
        $display("[TB] FAIL %s_dw1[%0d]: got %h, required %h", name, i,
                 got_q[got_seen + i].dw1, exp_q[i].dw1);
      end
      n_cmp++;
      if (got_q[got_seen + i].addr !== exp_q[i].addr) begin
        n_fail++;
        $display("[TB] FAIL %s_addr[%0d]: got %h, required %h", name, i,
                 got_q[got_seen + i].addr, exp_q[i].addr);
      end
    end
    got_seen = got_q.size();
    exp_q.delete();
  endtask

  task automatic run_page(input string name, input logic [63:0] a, input int unsigned q);
    int pg;
    pg = model_cur;
    start_page(pg, a, q);
    wait_free(pg, q == 0);
    check_tlps(name);
    model_cur = 3 - model_cur;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[20:0] = '0;
    return a;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) sample_cycle();
    n_cmp++; if (bus.tx_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_req: got %b, required 0", bus.tx_req); end
    n_cmp++; if (bus.trn_tsrc_rdy_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tsrc_rdy_n: got %b, required 1", bus.trn_tsrc_rdy_n); end
    n_cmp++; if (bus.trn_tsof_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tsof_n: got %b, required 1", bus.trn_tsof_n); end
    n_cmp++; if (bus.trn_teof_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_teof_n: got %b, required 1", bus.trn_teof_n); end
    n_cmp++; if (bus.trn_td !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_td: got %h, required 0", bus.trn_td); end
    n_cmp++; if (bus.trn_trem_n !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_trem_n: got %h, required 00", bus.trn_trem_n); end
    n_cmp++; if ({huge_page_free_1, huge_page_free_2} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_free: got %b, required 00", {huge_page_free_1, huge_page_free_2}); end
    drive_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_spec_page();
    run_page("spec_page", 64'h0000_0001_0020_0000, 200);
  endtask

  task automatic test_random_pages();
    gnt_rand = 1'b1;
    dst_mode = 2;
    for (int i = 0; i < 3; i++) run_page("random_page", rand_addr(), $urandom_range(1, 400));
    gnt_rand = 1'b0;
    dst_mode = 0;
  endtask

  task automatic test_zero_qwords();
    run_page("zero_qwords", rand_addr(), 0);
  endtask

  task automatic test_both_pages();
    logic [63:0] a2;
    int unsigned q2;
    int base;
    if (model_cur == 2) run_page("align_page", rand_addr(), $urandom_range(1, 100));
    a2 = rand_addr();
    q2 = $urandom_range(65, 300);
    drive_cycle();
    huge_page_addr_2 = a2; huge_page_qwords_2 = q2; huge_page_status_2 = 1'b1;
    start_page(1, rand_addr(), $urandom_range(65, 300));
    gen_expected(a2, q2);
    wait_free(1, 1'b0);
    wait_free(2, 1'b0);
    check_tlps("both_pages");
    // Page 1 is current again, so a lone page-2 unlock must be ignored
    drive_cycle();
    huge_page_status_2 = 1'b1;
    base = sof_cnt;
    repeat (30) sample_cycle();
    n_cmp++;
    if (sof_cnt != base || free_q.size() != free_seen) begin
      n_fail++;
      $display("[TB] FAIL cur_page_back_to_1: got %0d sof and %0d frees, required 0 and 0",
               sof_cnt - base, free_q.size() - free_seen);
    end
    drive_cycle();
    huge_page_status_2 = 1'b0;
  endtask

  task automatic test_backpressure();
    int base;
    base = stab_err;
    dst_mode = 1;
    cpl_coinc = 1'b1;
    run_page("backpressure", rand_addr(), 300);
    dst_mode = 0;
    cpl_coinc = 1'b0;
    n_cmp++;
    if (stab_err != base) begin
      n_fail++;
      $display("[TB] FAIL beat_stability: got %0d changed held beats, required 0", stab_err - base);
    end
  endtask

  task automatic test_credit();
    int pg;
    pg = model_cur;
    cpl_auto = 1'b0;
    start_page(pg, rand_addr(), 320);
`ifdef RD_OUTSTANDING_LIMIT_EN
    repeat (40) sample_cycle();
    n_cmp++;
    if (got_q.size() - got_seen != 2) begin
      n_fail++;
      $display("[TB] FAIL credit_stall: got %0d MRds, required 2", got_q.size() - got_seen);
    end
    cpl_req_n++;
    repeat (30) sample_cycle();
    n_cmp++;
    if (got_q.size() - got_seen != 3) begin
      n_fail++;
      $display("[TB] FAIL credit_release: got %0d MRds, required 3", got_q.size() - got_seen);
    end
`else
    repeat (60) sample_cycle();
    n_cmp++;
    if (got_q.size() - got_seen != 5) begin
      n_fail++;
      $display("[TB] FAIL no_credit_check: got %0d MRds, required 5", got_q.size() - got_seen);
    end
`endif
    cpl_auto = 1'b1;
    wait_free(pg, 1'b0);
    check_tlps("credit");
    model_cur = 3 - model_cur;
  endtask

  task automatic test_reset_mid();
    bit found;
    dst_mode = 4;
    start_page(model_cur, rand_addr(), 256);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      sample_cycle();
      if (!bus.trn_teof_n && !bus.trn_tsrc_rdy_n) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL reach_hdr1: got no held eof beat in 200 cycles, required one");
    end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.trn_tsrc_rdy_n !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_tsrc_rdy_n: got %b, required 1", bus.trn_tsrc_rdy_n); end
    n_cmp++; if (bus.tx_req !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_tx_req: got %b, required 0", bus.tx_req); end
    n_cmp++; if (bus.trn_teof_n !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_teof_n: got %b, required 1", bus.trn_teof_n); end
    huge_page_status_1 = 1'b0;
    huge_page_status_2 = 1'b0;
    repeat (3) drive_cycle();
    reset_n = 1'b1;
    dst_mode = 0;
    exp_q.delete();
    got_seen = got_q.size();
    model_tag = 0;
    model_cur = 1;
    run_page("after_reset", rand_addr(), 100);
  endtask

  initial begin
    reset_n = 1'b0;
    dst_mode = 0;
    gnt_rand = 1'b0;
    cpl_auto = 1'b1;
    cpl_coinc = 1'b0;
    cpl_req_n = 0;
    model_tag = 0;
    model_cur = 1;
    got_seen = 0;
    free_seen = 0;
    start_cyc = 0;
    cfg_completer_id = 16'($urandom);
    huge_page_addr_1 = '0;
    huge_page_addr_2 = '0;
    huge_page_qwords_1 = '0;
    huge_page_qwords_2 = '0;
    huge_page_status_1 = 1'b0;
    huge_page_status_2 = 1'b0;
    test_reset();
    test_spec_page();
    test_random_pages();
    test_zero_qwords();
    test_both_pages();
    test_backpressure();
    test_credit();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
